// File: rtl/axi_request_proxy_rw.sv
// AXI-Stream request to AXI4-Lite read/write proxy, one transaction in flight.
// Define PROXY_ERR_COUNT_EN to add the saturating error-response counter.
module axi_request_proxy_rw #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
`ifdef PROXY_ERR_COUNT_EN
    input  logic                       err_clear,
    output logic [15:0]                err_count,
`endif
    input  logic [DATA_W+ADDR_W+7:0]   S_AXIS_TDATA,
    input  logic                       S_AXIS_TVALID,
    output logic                       S_AXIS_TREADY,
    output logic [DATA_W+15:0]         M_AXIS_TDATA,
    output logic                       M_AXIS_TVALID,
    input  logic                       M_AXIS_TREADY,
    output logic [ADDR_W-1:0]          M_AXI_AWADDR,
    output logic [2:0]                 M_AXI_AWPROT,
    output logic                       M_AXI_AWVALID,
    input  logic                       M_AXI_AWREADY,
    output logic [DATA_W-1:0]          M_AXI_WDATA,
    output logic [DATA_W/8-1:0]        M_AXI_WSTRB,
    output logic                       M_AXI_WVALID,
    input  logic                       M_AXI_WREADY,
    input  logic [1:0]                 M_AXI_BRESP,
    input  logic                       M_AXI_BVALID,
    output logic                       M_AXI_BREADY,
    output logic [ADDR_W-1:0]          M_AXI_ARADDR,
    output logic [2:0]                 M_AXI_ARPROT,
    output logic                       M_AXI_ARVALID,
    input  logic                       M_AXI_ARREADY,
    input  logic [DATA_W-1:0]          M_AXI_RDATA,
    input  logic [1:0]                 M_AXI_RRESP,
    input  logic                       M_AXI_RVALID,
    output logic                       M_AXI_RREADY
);

    localparam int OP_BIT = DATA_W + ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ,
        ST_RRESP,
        ST_SEND
    } state_t;

    state_t              state_q, state_d;
    logic                s_tready_q, s_tready_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic [DATA_W+15:0]  m_tdata_q, m_tdata_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                op_q, op_d;
    logic [6:0]          tag_q, tag_d;

    logic req_hs;
    logic b_hs;
    logic r_hs;

    assign req_hs = S_AXIS_TVALID & s_tready_q;
    assign b_hs   = bready_q & M_AXI_BVALID;
    assign r_hs   = rready_q & M_AXI_RVALID;

    always_comb begin
        state_d    = state_q;
        s_tready_d = s_tready_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        tag_d      = tag_q;

        unique case (state_q)
            ST_IDLE: begin
                // Ready rises the cycle after IDLE is entered, drops on accept.
                s_tready_d = 1'b1;
                if (req_hs) begin
                    s_tready_d = 1'b0;
                    wdata_d    = S_AXIS_TDATA[DATA_W-1:0];
                    addr_d     = S_AXIS_TDATA[OP_BIT-1:DATA_W];
                    op_d       = S_AXIS_TDATA[OP_BIT];
                    tag_d      = S_AXIS_TDATA[OP_BIT+7:OP_BIT+1];
                    if (S_AXIS_TDATA[OP_BIT]) begin
                        arvalid_d = 1'b1;
                        state_d   = ST_READ;
                    end else begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                awvalid_d = awvalid_q & ~M_AXI_AWREADY;
                wvalid_d  = wvalid_q & ~M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (b_hs) begin
                    bready_d   = 1'b0;
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = {tag_q, op_q, 6'b0, M_AXI_BRESP,
                                  {DATA_W{1'b0}}};
                    state_d    = ST_SEND;
                end
            end
            ST_READ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RRESP;
                end
            end
            ST_RRESP: begin
                if (r_hs) begin
                    rready_d   = 1'b0;
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = {tag_q, op_q, 6'b0, M_AXI_RRESP,
                                  M_AXI_RDATA};
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (M_AXIS_TREADY) begin
                    m_tvalid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            s_tready_q <= s_tready_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
        end
    end

`ifdef PROXY_ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;
    logic        err_hit;

    assign err_hit = (b_hs && (M_AXI_BRESP != 2'b00)) ||
                     (r_hs && (M_AXI_RRESP != 2'b00));

    // A new error coincident with a clear leaves a count of one.
    always_comb begin
        err_count_d = err_count_q;
        if (err_hit) begin
            if (err_clear) begin
                err_count_d = 16'd1;
            end else if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
        end else if (err_clear) begin
            err_count_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_count_q <= 16'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    assign S_AXIS_TREADY = s_tready_q;
    assign M_AXIS_TVALID = m_tvalid_q;
    assign M_AXIS_TDATA  = m_tdata_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_request_proxy_rw.sv
// Bench for axi_request_proxy_rw: vector table, AXI4-Lite slave model
// and a response scoreboard, all stepped from one process at negedge.
module tb_axi_request_proxy_rw;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic [DW+AW+7:0]  s_tdata;
    logic              s_tvalid, s_tready;
    logic [DW+15:0]    m_tdata;
    logic              m_tvalid, m_tready;
    logic [AW-1:0]     awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic              awvalid, awready, wvalid, wready;
    logic [DW-1:0]     wdata, rdata;
    logic [DW/8-1:0]   wstrb;
    logic [1:0]        bresp, rresp;
    logic              bvalid, bready, arvalid, arready;
    logic              rvalid, rready;
`ifdef PROXY_ERR_COUNT_EN
    logic              err_clear;
    logic [15:0]       err_count;
`endif

    axi_request_proxy_rw #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .resetn(resetn),
`ifdef PROXY_ERR_COUNT_EN
        .err_clear(err_clear),
        .err_count(err_count),
`endif
        .S_AXIS_TDATA(s_tdata),
        .S_AXIS_TVALID(s_tvalid),
        .S_AXIS_TREADY(s_tready),
        .M_AXIS_TDATA(m_tdata),
        .M_AXIS_TVALID(m_tvalid),
        .M_AXIS_TREADY(m_tready),
        .M_AXI_AWADDR(awaddr),
        .M_AXI_AWPROT(awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata),
        .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr),
        .M_AXI_ARPROT(arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata),
        .M_AXI_RRESP(rresp),
        .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    typedef struct {
        bit        op;
        bit [6:0]  tag;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        bit [1:0]  resp;
        int        aw_w, w_w, ar_w, b_w, r_w;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit aw_got, w_got, b_owed, r_owed;
    int n_aw, n_w, n_b, n_ar, n_r, n_rsp, n_arv;
    logic [31:0] log_awaddr, log_wdata, log_araddr;
    logic [1:0]  bresp_cfg, rresp_cfg;
    logic [31:0] rdata_cfg;
    int rsp_hold_n, hold_used, last_hold, hold_traffic;
    logic [47:0] hold_data;
    bit clr_on_err, clr_now;
    logic [47:0] sb[$];
    int acc_cyc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit op, bit [6:0] tag, bit [31:0] addr,
                                bit [31:0] wd, bit [31:0] rd, bit [1:0] resp,
                                int aw, int w, int ar, int b, int r);
        vec_t v;
        v.op = op; v.tag = tag; v.addr = addr; v.wdata = wd;
        v.rdata = rd; v.resp = resp;
        v.aw_w = aw; v.w_w = w; v.ar_w = ar; v.b_w = b; v.r_w = r;
        return v;
    endfunction

    function automatic logic [47:0] exp_rsp(vec_t v);
        logic [31:0] d;
        d = v.op ? v.rdata : 32'h0;
        return {v.tag, v.op, 6'b0, v.resp, d};
    endfunction

    // Slave + response sink; decides inputs for the cycle now starting.
    task automatic model();
        if (!resetn) begin
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; b_owed = 0; r_owed = 0;
            hold_used = 0;
            awready = 0; wready = 0; bvalid = 0; arready = 0;
            rvalid = 0; m_tready = 0;
            sb.delete();
`ifdef PROXY_ERR_COUNT_EN
            err_clear = 0;
`endif
            return;
        end
        if (aw_got) chk("awvalid_drop", 64'(awvalid), 0);
        if (w_got) chk("wvalid_drop", 64'(wvalid), 0);
        if (bready) chk("bready_after_aw_w", 64'({aw_got, w_got}), 3);
        if (arvalid) n_arv++;
        if (m_tvalid) begin
            if (hold_used < rsp_hold_n) begin
                m_tready = 0;
                if (hold_used == 0) begin
                    hold_data = m_tdata;
                    hold_traffic = n_aw + n_w + n_ar;
                end else begin
                    chk("hold_tdata", 64'(m_tdata), 64'(hold_data));
                    chk("hold_s_tready", 64'(s_tready), 0);
                    chk("hold_traffic", 64'(n_aw + n_w + n_ar),
                        64'(hold_traffic));
                end
                hold_used++;
            end else begin
                m_tready = 1;
                last_hold = hold_used;
                hold_used = 0;
                n_rsp++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected act=%0h exp=none", m_tdata);
                end else begin
                    chk("rsp_tdata", 64'(m_tdata), 64'(sb.pop_front()));
                end
            end
        end else begin
            m_tready = 0;
        end
`ifdef PROXY_ERR_COUNT_EN
        err_clear = clr_now;
`endif
        if (b_owed) begin
            if (b_cnt >= b_wait) begin
                bvalid = 1;
                bresp = bresp_cfg;
                if (bready) begin
                    n_b++; b_owed = 0; b_cnt = 0;
                    aw_got = 0; w_got = 0;
`ifdef PROXY_ERR_COUNT_EN
                    if (clr_on_err) err_clear = 1;
`endif
                end
            end else begin
                bvalid = 0;
                b_cnt++;
            end
        end else begin
            bvalid = 0;
        end
        if (r_owed) begin
            if (r_cnt >= r_wait) begin
                rvalid = 1;
                rdata = rdata_cfg;
                rresp = rresp_cfg;
                if (rready) begin
                    n_r++; r_owed = 0; r_cnt = 0;
                end
            end else begin
                rvalid = 0;
                r_cnt++;
            end
        end else begin
            rvalid = 0;
        end
        if (awvalid) begin
            if (aw_cnt >= aw_wait) begin
                awready = 1; n_aw++; log_awaddr = awaddr;
                aw_got = 1; aw_cnt = 0;
            end else begin
                awready = 0; aw_cnt++;
            end
        end else begin
            awready = 0;
        end
        if (wvalid) begin
            if (w_cnt >= w_wait) begin
                wready = 1; n_w++; log_wdata = wdata;
                w_got = 1; w_cnt = 0;
            end else begin
                wready = 0; w_cnt++;
            end
        end else begin
            wready = 0;
        end
        if (aw_got && w_got && !b_owed) b_owed = 1;
        if (arvalid) begin
            if (ar_cnt >= ar_wait) begin
                arready = 1; n_ar++; log_araddr = araddr;
                r_owed = 1; ar_cnt = 0;
            end else begin
                arready = 0; ar_cnt++;
            end
        end else begin
            arready = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        model();
    endtask

    task automatic cfg(vec_t v);
        aw_wait = v.aw_w; w_wait = v.w_w; ar_wait = v.ar_w;
        b_wait = v.b_w; r_wait = v.r_w;
        bresp_cfg = v.resp; rresp_cfg = v.resp; rdata_cfg = v.rdata;
    endtask

    task automatic send_req(vec_t v);
        int k;
        s_tdata = {v.tag, v.op, v.addr, v.wdata};
        s_tvalid = 1;
        k = 0;
        while (!s_tready && k < 100) begin
            tick();
            k++;
        end
        if (!s_tready) begin
            chk("req_accept_timeout", 64'(s_tready), 1);
        end else begin
            sb.push_back(exp_rsp(v));
            acc_cyc = cyc;
        end
        tick();
        s_tvalid = 0;
    endtask

    task automatic wait_rsp(int maxc);
        int k;
        k = 0;
        while (sb.size() != 0 && k < maxc) begin
            tick();
            k++;
        end
        if (sb.size() != 0) chk("rsp_timeout", 64'(sb.size()), 0);
        sb.delete();
    endtask

    vec_t vt[8];
    vec_t v;

    initial begin
        int nb0, nr0, naw0, nw0, narv0, nrsp0, k;
        resetn = 0; s_tvalid = 0; s_tdata = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0; m_tready = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        bresp_cfg = 0; rresp_cfg = 0; rdata_cfg = 0;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_rsp = 0; n_arv = 0;
        rsp_hold_n = 0; last_hold = 0; clr_on_err = 0; clr_now = 0;
        log_awaddr = 0; log_wdata = 0; log_araddr = 0;
`ifdef PROXY_ERR_COUNT_EN
        err_clear = 0;
`endif
        vt[0] = mk(0, 7'h05, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
        vt[1] = mk(1, 7'h7F, 32'h0000_2004, 0, 32'h1234_5678, 0, 0, 0, 3, 0, 0);
        vt[2] = mk(0, 7'h11, 32'h0000_0030, 32'hA5A5_5A5A, 0, 0, 3, 0, 0, 0, 0);
        vt[3] = mk(0, 7'h12, 32'h0000_0034, 32'h0F0F_F0F0, 0, 0, 0, 3, 0, 0, 0);
        vt[4] = mk(0, 7'h21, 32'h0000_0040, 32'h1111_2222, 0, 2, 0, 0, 0, 1, 0);
        vt[5] = mk(1, 7'h22, 32'h0000_0044, 0, 32'hCAFE_F00D, 3, 0, 0, 0, 0, 2);
        vt[6] = mk(1, 7'h00, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 2);
        vt[7] = mk(0, 7'h55, 32'h8000_0000, 32'h0, 0, 0, 1, 1, 0, 4, 0);

        repeat (3) tick();
        chk("rst_s_tready", 64'(s_tready), 0);
        chk("rst_m_tvalid", 64'(m_tvalid), 0);
        chk("rst_m_tdata", 64'(m_tdata), 0);
        chk("rst_axi_vr", 64'({awvalid, wvalid, bready, arvalid, rready}), 0);
`ifdef PROXY_ERR_COUNT_EN
        chk("rst_err_count", 64'(err_count), 0);
`endif
        resetn = 1;
        tick();
        chk("tready_after_reset", 64'(s_tready), 1);

        for (int i = 0; i < 8; i++) begin
            v = vt[i];
            cfg(v);
            nb0 = n_b; nr0 = n_r; naw0 = n_aw; nw0 = n_w; narv0 = n_arv;
            send_req(v);
            if (i == 0) begin
                k = 0;
                while (!s_tready && k < 50) begin
                    tick();
                    k++;
                end
                chk("write_turnaround", 64'(cyc - acc_cyc), 5);
            end
            wait_rsp(200);
            if (!v.op) begin
                chk("awaddr", 64'(log_awaddr), 64'(v.addr));
                chk("wdata", 64'(log_wdata), 64'(v.wdata));
                chk("wstrb_prot", 64'({wstrb, awprot}), 64'h78);
                chk("aw_count", 64'(n_aw - naw0), 1);
                chk("w_count", 64'(n_w - nw0), 1);
                chk("b_count", 64'(n_b - nb0), 1);
            end else begin
                chk("araddr", 64'(log_araddr), 64'(v.addr));
                chk("arprot", 64'(arprot), 0);
                chk("r_count", 64'(n_r - nr0), 1);
                chk("arvalid_cycles", 64'(n_arv - narv0), 64'(v.ar_w + 1));
            end
`ifdef PROXY_ERR_COUNT_EN
            if (i == 5) chk("err_count_two", 64'(err_count), 2);
`endif
        end

`ifdef PROXY_ERR_COUNT_EN
        v = mk(0, 7'h2A, 32'h0000_0050, 32'h5, 0, 2, 0, 0, 0, 0, 0);
        cfg(v);
        clr_on_err = 1;
        send_req(v);
        wait_rsp(200);
        clr_on_err = 0;
        chk("err_clear_vs_inc", 64'(err_count), 1);
        clr_now = 1;
        tick();
        clr_now = 0;
        tick();
        chk("err_clear_only", 64'(err_count), 0);
`endif

        v = mk(1, 7'h3C, 32'h0000_0100, 0, 32'h600D_D00D, 0, 0, 0, 0, 0, 0);
        cfg(v);
        rsp_hold_n = 10;
        send_req(v);
        wait_rsp(200);
        rsp_hold_n = 0;
        chk("hold_cycles", 64'(last_hold), 10);

        v = mk(0, 7'h33, 32'h0000_0200, 32'h7777_8888, 0, 0, 0, 0, 0, 5, 0);
        cfg(v);
        send_req(v);
        k = 0;
        while (!bready && k < 50) begin
            tick();
            k++;
        end
        chk("bready_seen", 64'(bready), 1);
        resetn = 0;
        tick();
        chk("midrst_vr",
            64'({s_tready, m_tvalid, awvalid, wvalid, bready, arvalid, rready}),
            0);
        chk("midrst_tdata", 64'(m_tdata), 0);
        resetn = 1;
        v.b_w = 0;
        cfg(v);
        nrsp0 = n_rsp;
        repeat (20) tick();
        chk("no_stale_rsp", 64'(n_rsp - nrsp0), 0);
        v = mk(1, 7'h44, 32'h0000_0300, 0, 32'h0BAD_F00D, 0, 0, 0, 1, 0, 1);
        cfg(v);
        nr0 = n_r;
        send_req(v);
        wait_rsp(200);
        chk("post_rst_araddr", 64'(log_araddr), 64'(v.addr));
        chk("post_rst_r_count", 64'(n_r - nr0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_request_proxy_rw.md
Name: axi_request_proxy_rw

Overview:
Parametrised read/write successor to the write-only request proxy. Accepts one-word AXI-Stream request packets carrying opcode, tag, address and data. Executes each request as a single AXI4-Lite read or write on the system interconnect. Returns one AXI-Stream response packet per request, carrying tag, opcode, RESP code and read data. The AXI4-Lite master is implemented in this block; there is no separate master core. One transaction is outstanding at a time.

Parameters:
ADDR_W, 32, AXI address width (12..64)
DATA_W, 32, AXI data width (32 or 64)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
S_AXIS_TDATA  in  DATA_W+ADDR_W+8  request; [DATA_W-1:0]=wdata, [DATA_W+ADDR_W-1:DATA_W]=addr, bit DATA_W+ADDR_W=op (0 write, 1 read), top 7 bits=tag
S_AXIS_TVALID  in  1  request valid
S_AXIS_TREADY  out  1  request ready
M_AXIS_TDATA  out  DATA_W+16  response; [DATA_W-1:0]=rdata (0 for writes), [DATA_W+1:DATA_W]=resp, [DATA_W+7:DATA_W+2]=0, [DATA_W+8]=op, [DATA_W+15:DATA_W+9]=tag
M_AXIS_TVALID  out  1  response valid
M_AXIS_TREADY  in  1  response ready
M_AXI_AW*/W*/B*/AR*/R*  mixed  per AXI4-Lite  AWADDR/ARADDR ADDR_W, WDATA/RDATA DATA_W, WSTRB DATA_W/8, AWPROT/ARPROT 3, BRESP/RRESP 2

Behaviour:
- Reset: clk and resetn are as stated above (synchronous, active-low resetn). While resetn=0:
  - S_AXIS_TREADY, M_AXIS_TVALID, AWVALID, WVALID, BREADY, ARVALID and RREADY are all 0.
  - M_AXIS_TDATA is 0.
  - FSM is in IDLE.
- Reset asserted mid-transaction abandons the transaction. No response is emitted.
- AWPROT=ARPROT=0 constant. WSTRB is all ones.
- All outputs are registered.
- IDLE state:
  - S_AXIS_TREADY=1; it rises one cycle after reset is released.
  - On a request handshake (TVALID&TREADY, cycle N): latch addr, wdata, op and tag; drop TREADY at N+1.
  - Go to WRITE (op=0) or READ (op=1).
- WRITE state:
  - AWVALID=1 and WVALID=1, both from N+1.
  - Each VALID drops independently the cycle after its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - When both have completed, go to WRESP.
- WRESP state:
  - BREADY=1 until the B handshake.
  - On the handshake, capture BRESP, set rdata field=0 and go to SEND.
- READ state: ARVALID=1 until the AR handshake, then go to RRESP.
- RRESP state:
  - RREADY=1 until the R handshake.
  - On the handshake, capture RDATA and RRESP, then go to SEND.
- SEND state:
  - M_AXIS_TVALID=1 with stable TDATA until M_AXIS_TREADY is sampled high.
  - Then clear TVALID, go to IDLE and raise S_AXIS_TREADY on the next cycle.
- Back-to-back throughput: minimum write turnaround is 5 cycles from request accept to the next TREADY=1, given zero-wait slaves.
- Error responses (SLVERR=2, DECERR=3) pass through unchanged. They never stall the FSM.
- Unused top bits of S_AXIS_TDATA beyond the op/tag definition: none exist; all 8 upper bits are defined.

Optional Feature:
- Macro: PROXY_ERR_COUNT_EN.
- When defined:
  - Adds output err_count [15:0].
  - err_count increments on every B or R handshake whose resp != 0, and saturates at 16'hFFFF.
  - Reset clears err_count to 0.
  - Adds input err_clear [1]: a one-cycle pulse zeroes err_count. An increment in the same cycle as err_clear wins, giving err_count=1.
- When undefined: neither port exists and no counter logic is present.

Test Plan:
1. Write, zero-wait slave: request op=0, tag=5, addr=0x0000_1000, wdata=0xDEADBEEF -> AWADDR=0x1000 and WDATA=0xDEADBEEF at N+1; response has tag=5, op=0, resp=0, rdata=0.
2. Read: op=1, tag=0x7F, addr=0x2004; slave returns RDATA=0x12345678, RRESP=0 -> response rdata=0x12345678, tag=0x7F, op=1; ARVALID held 4 cycles while ARREADY is held low 3 cycles.
3. AW/W skew: WREADY 3 cycles before AWREADY, then the reverse -> WVALID drops after its own handshake, BREADY is asserted only after both handshakes, and exactly one B is accepted.
4. Response backpressure: M_AXIS_TREADY low for 10 cycles -> TVALID and TDATA stay stable, S_AXIS_TREADY stays 0, and no new AXI traffic occurs.
5. Error path: BRESP=2 then RRESP=3 -> resp fields 2 and 3; with PROXY_ERR_COUNT_EN, err_count=2; err_clear coincident with a third error -> err_count=1.
6. Reset mid-transaction: resetn low during WRESP -> all VALID/READY outputs are 0 next cycle; after release, no stale response is emitted and a new read completes normally.
